// File: rtl/uart_link.sv
// uart_link: single-clock 8N1 UART transceiver.
// A shared oversampling tick generator drives an 8N1 transmitter and a
// 16x-oversampled 8N1 receiver. The serial input passes through a 2-flop
// synchronizer before the receiver sees it.
// Optional feature: define UART_FRAME_ERR_EN to add the frame_err output.
// A stop bit sampled low then pulses frame_err instead of delivering the byte.
module uart_link #(
   parameter int TICK_DIV   = 5,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_start,
   input  logic [7:0] din,
   output logic       tx,
   output logic       tx_done_flag,
   input  logic       rx,
   output logic [7:0] dout,
   output logic       rx_done_flag
`ifdef UART_FRAME_ERR_EN
   ,
   output logic       frame_err
`endif
);

   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int OS_W  = $clog2(OVERSAMPLE);

   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
   localparam logic [OS_W-1:0]  OS_HALF  = OS_W'(OVERSAMPLE / 2 - 1);

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   // Baud generator
   logic [DIV_W-1:0] div_cnt;
   logic             s_tick;

   // Transmitter
   tx_state_t        tx_state;
   logic [OS_W-1:0]  tx_os_cnt;
   logic [2:0]       tx_bit_cnt;
   logic [7:0]       tx_shreg;

   // Receiver
   logic             rx_sync_p0;
   logic             rx_sync_p1;
   logic             rx_line;
   rx_state_t        rx_state;
   logic [OS_W-1:0]  rx_os_cnt;
   logic [2:0]       rx_bit_cnt;
   logic [7:0]       rx_shreg;

   // Free-running divider; the tick is shared by both directions.
   always_ff @(posedge clk) begin
      if (!reset) begin
         div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

   assign s_tick = (div_cnt == DIV_LAST);

   // Transmit FSM: the serial line is a register, so it never glitches.
   always_ff @(posedge clk) begin
      if (!reset) begin
         tx_state     <= TX_IDLE;
         tx           <= 1'b1;
         tx_done_flag <= 1'b0;
         tx_os_cnt    <= '0;
         tx_bit_cnt   <= '0;
      end else begin
         tx_done_flag <= 1'b0;
         case (tx_state)
            TX_IDLE: begin
               tx <= 1'b1;
               if (tx_start) begin
                  tx_shreg   <= din;
                  tx_os_cnt  <= '0;
                  tx_bit_cnt <= '0;
                  tx         <= 1'b0;
                  tx_state   <= TX_START;
               end
            end
            TX_START: begin
               if (s_tick) begin
                  if (tx_os_cnt == OS_LAST) begin
                     tx_os_cnt <= '0;
                     tx        <= tx_shreg[0];
                     tx_state  <= TX_DATA;
                  end else begin
                     tx_os_cnt <= tx_os_cnt + 1'b1;
                  end
               end
            end
            TX_DATA: begin
               if (s_tick) begin
                  if (tx_os_cnt == OS_LAST) begin
                     tx_os_cnt <= '0;
                     tx_shreg  <= {1'b0, tx_shreg[7:1]};
                     if (tx_bit_cnt == 3'd7) begin
                        tx       <= 1'b1;
                        tx_state <= TX_STOP;
                     end else begin
                        tx         <= tx_shreg[1];
                        tx_bit_cnt <= tx_bit_cnt + 1'b1;
                     end
                  end else begin
                     tx_os_cnt <= tx_os_cnt + 1'b1;
                  end
               end
            end
            TX_STOP: begin
               if (s_tick) begin
                  if (tx_os_cnt == OS_LAST) begin
                     tx_os_cnt    <= '0;
                     tx_done_flag <= 1'b1;
                     tx_state     <= TX_IDLE;
                  end else begin
                     tx_os_cnt <= tx_os_cnt + 1'b1;
                  end
               end
            end
            default: begin
               tx       <= 1'b1;
               tx_state <= TX_IDLE;
            end
         endcase
      end
   end

   // Two-flop synchronizer for the asynchronous serial input.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_sync_p0 <= 1'b1;
         rx_sync_p1 <= 1'b1;
      end else begin
         rx_sync_p0 <= rx;
         rx_sync_p1 <= rx_sync_p0;
      end
   end

   assign rx_line = rx_sync_p1;

   // Receive FSM: start edge re-checked at half a bit, data sampled mid-bit.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_state     <= RX_IDLE;
         rx_os_cnt    <= '0;
         rx_bit_cnt   <= '0;
         dout         <= 8'h00;
         rx_done_flag <= 1'b0;
`ifdef UART_FRAME_ERR_EN
         frame_err    <= 1'b0;
`endif
      end else begin
         rx_done_flag <= 1'b0;
`ifdef UART_FRAME_ERR_EN
         frame_err    <= 1'b0;
`endif
         case (rx_state)
            RX_IDLE: begin
               if (!rx_line) begin
                  rx_os_cnt <= '0;
                  rx_state  <= RX_START;
               end
            end
            RX_START: begin
               if (s_tick) begin
                  if (rx_os_cnt == OS_HALF) begin
                     rx_os_cnt  <= '0;
                     rx_bit_cnt <= '0;
                     // A line that went high again was only a glitch.
                     rx_state   <= rx_line ? RX_IDLE : RX_DATA;
                  end else begin
                     rx_os_cnt <= rx_os_cnt + 1'b1;
                  end
               end
            end
            RX_DATA: begin
               if (s_tick) begin
                  if (rx_os_cnt == OS_LAST) begin
                     rx_os_cnt <= '0;
                     rx_shreg  <= {rx_line, rx_shreg[7:1]};
                     if (rx_bit_cnt == 3'd7) begin
                        rx_state <= RX_STOP;
                     end else begin
                        rx_bit_cnt <= rx_bit_cnt + 1'b1;
                     end
                  end else begin
                     rx_os_cnt <= rx_os_cnt + 1'b1;
                  end
               end
            end
            RX_STOP: begin
               if (s_tick) begin
                  if (rx_os_cnt == OS_LAST) begin
                     rx_os_cnt <= '0;
                     rx_state  <= RX_IDLE;
`ifdef UART_FRAME_ERR_EN
                     if (!rx_line) begin
                        frame_err <= 1'b1;
                     end else begin
                        dout         <= rx_shreg;
                        rx_done_flag <= 1'b1;
                     end
`else
                     dout         <= rx_shreg;
                     rx_done_flag <= 1'b1;
`endif
                  end else begin
                     rx_os_cnt <= rx_os_cnt + 1'b1;
                  end
               end
            end
            default: begin
               rx_state <= RX_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_link.sv
// Testbench for uart_link: loopback scoreboard plus directed serial scenarios.
module tb_uart_link;

   logic       clk;
   logic       reset;
   logic       tx_start;
   logic [7:0] din;
   logic       tx;
   logic       tx_done_flag;
   logic       rx_line;
   logic [7:0] dout;
   logic       rx_done_flag;
`ifdef UART_FRAME_ERR_EN
   logic       frame_err;
`endif

   logic       loopback;
   logic       rx_drv;

   int checks;
   int failures;
   int rx_cnt;
   int tx_cnt;
   int ferr_cnt;
   logic [7:0] exp_q[$];

   assign rx_line = loopback ? tx : rx_drv;

   uart_link dut (
      .clk          (clk),
      .reset        (reset),
      .tx_start     (tx_start),
      .din          (din),
      .tx           (tx),
      .tx_done_flag (tx_done_flag),
      .rx           (rx_line),
      .dout         (dout),
      .rx_done_flag (rx_done_flag)
`ifdef UART_FRAME_ERR_EN
      ,
      .frame_err    (frame_err)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard: every received byte is compared with the oldest expected one.
   always @(negedge clk) begin
      if (tx_done_flag) tx_cnt++;
`ifdef UART_FRAME_ERR_EN
      if (frame_err) ferr_cnt++;
`endif
      if (rx_done_flag) begin
         rx_cnt++;
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL rx_unexpected: got dout=%02h, required no byte", dout);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (dout !== e) begin
               failures++;
               $display("FAIL rx_data: got %02h, required %02h", dout, e);
            end
         end
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge clk);
      #1;
      din      = b;
      tx_start = 1'b1;
      @(posedge clk);
      #1;
      tx_start = 1'b0;
   endtask

   task automatic drive_rx_frame(input logic [7:0] b, input logic stop_lvl, input int stop_len);
      rx_drv = 1'b0;
      wait_clks(80);
      for (int i = 0; i < 8; i++) begin
         rx_drv = b[i];
         wait_clks(80);
      end
      rx_drv = stop_lvl;
      wait_clks(stop_len);
      rx_drv = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b, required 1", tx); end
      checks++;
      if (tx_done_flag !== 1'b0) begin failures++; $display("FAIL reset_tx_done: got %b, required 0", tx_done_flag); end
      checks++;
      if (dout !== 8'h00) begin failures++; $display("FAIL reset_dout: got %02h, required 00", dout); end
      checks++;
      if (rx_done_flag !== 1'b0) begin failures++; $display("FAIL reset_rx_done: got %b, required 0", rx_done_flag); end
      @(posedge clk);
      #1;
      reset = 1'b1;
      wait_clks(10);
   endtask

   task automatic test_loopback();
      logic [7:0] bytes [4];
      bytes[0] = 8'h00;
      bytes[1] = 8'h55;
      bytes[2] = 8'hA5;
      bytes[3] = 8'hFF;
      loopback = 1'b1;
      for (int k = 0; k < 4; k++) begin
         int n;
         int rx0;
         int tx0;
         bit seen;
         rx0  = rx_cnt;
         tx0  = tx_cnt;
         seen = 1'b0;
         n    = 0;
         exp_q.push_back(bytes[k]);
         send_byte(bytes[k]);
         while (!seen && n < 900) begin
            @(negedge clk);
            n++;
            if (tx_done_flag) seen = 1'b1;
         end
         checks++;
         if (!seen) begin
            failures++;
            $display("FAIL loop_tx_done_timeout: byte %02h no tx_done within %0d clocks", bytes[k], n);
         end else if (n < 795 || n > 805) begin
            failures++;
            $display("FAIL loop_tx_done_time: got %0d clocks, required 800+-5", n);
         end
         repeat (1000 - n) @(negedge clk);
         checks++;
         if (rx_cnt - rx0 !== 1) begin
            failures++;
            $display("FAIL loop_rx_count: byte %02h got %0d rx_done, required 1", bytes[k], rx_cnt - rx0);
         end
         checks++;
         if (tx_cnt - tx0 !== 1) begin
            failures++;
            $display("FAIL loop_tx_count: byte %02h got %0d tx_done, required 1", bytes[k], tx_cnt - tx0);
         end
      end
   endtask

   task automatic test_tx_wave();
      logic [9:0] exp_bits;
      exp_bits = 10'b10_0000_0010;   // bit 0 = start, bit 9 = stop
      loopback = 1'b1;
      exp_q.push_back(8'h01);
      send_byte(8'h01);
      repeat (39) @(posedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checks++;
         if (tx !== exp_bits[i]) begin
            failures++;
            $display("FAIL tx_wave_bit%0d: got %b, required %b", i, tx, exp_bits[i]);
         end
         if (i < 9) repeat (80) @(posedge clk);
      end
      wait_clks(300);
   endtask

   task automatic test_busy();
      int rx0;
      int tx0;
      rx0 = rx_cnt;
      tx0 = tx_cnt;
      loopback = 1'b1;
      exp_q.push_back(8'h3C);
      send_byte(8'h3C);
      wait_clks(200);
      send_byte(8'hC3);
      wait_clks(1100);
      checks++;
      if (tx_cnt - tx0 !== 1) begin
         failures++;
         $display("FAIL busy_tx_count: got %0d tx_done, required 1", tx_cnt - tx0);
      end
      checks++;
      if (rx_cnt - rx0 !== 1) begin
         failures++;
         $display("FAIL busy_rx_count: got %0d rx_done, required 1", rx_cnt - rx0);
      end
   endtask

   task automatic test_glitch();
      int rx0;
      rx0 = rx_cnt;
      rx_drv   = 1'b1;
      loopback = 1'b0;
      wait_clks(20);
      rx_drv = 1'b0;
      wait_clks(20);
      rx_drv = 1'b1;
      wait_clks(200);
      checks++;
      if (rx_cnt - rx0 !== 0) begin
         failures++;
         $display("FAIL glitch_rx_count: got %0d rx_done, required 0", rx_cnt - rx0);
      end
      exp_q.push_back(8'h5A);
      drive_rx_frame(8'h5A, 1'b1, 80);
      wait_clks(200);
      checks++;
      if (rx_cnt - rx0 !== 1) begin
         failures++;
         $display("FAIL glitch_after_rx_count: got %0d rx_done, required 1", rx_cnt - rx0);
      end
   endtask

   task automatic test_reset_mid();
      int rx0;
      int tx0;
      loopback = 1'b1;
      send_byte(8'hF0);
      wait_clks(300);
      rx0 = rx_cnt;
      tx0 = tx_cnt;
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      checks++;
      if (tx !== 1'b1) begin
         failures++;
         $display("FAIL reset_mid_tx: got %b, required 1", tx);
      end
      wait_clks(900);
      checks++;
      if (tx_cnt - tx0 !== 0 || rx_cnt - rx0 !== 0) begin
         failures++;
         $display("FAIL reset_mid_no_done: got tx_done=%0d rx_done=%0d, required 0 0",
                  tx_cnt - tx0, rx_cnt - rx0);
      end
      rx0 = rx_cnt;
      exp_q.push_back(8'h0F);
      send_byte(8'h0F);
      wait_clks(1000);
      checks++;
      if (rx_cnt - rx0 !== 1) begin
         failures++;
         $display("FAIL reset_mid_fresh_rx: got %0d rx_done, required 1", rx_cnt - rx0);
      end
   endtask

`ifdef UART_FRAME_ERR_EN
   task automatic test_frame_err();
      int rx0;
      int f0;
      rx0 = rx_cnt;
      f0  = ferr_cnt;
      rx_drv   = 1'b1;
      loopback = 1'b0;
      wait_clks(50);
      drive_rx_frame(8'h81, 1'b0, 60);
      wait_clks(300);
      checks++;
      if (ferr_cnt - f0 !== 1) begin
         failures++;
         $display("FAIL frame_err_count: got %0d pulses, required 1", ferr_cnt - f0);
      end
      checks++;
      if (rx_cnt - rx0 !== 0) begin
         failures++;
         $display("FAIL frame_err_rx_done: got %0d rx_done, required 0", rx_cnt - rx0);
      end
      checks++;
      if (dout !== 8'h0F) begin
         failures++;
         $display("FAIL frame_err_dout: got %02h, required 0F", dout);
      end
   endtask
`endif

   initial begin
      checks   = 0;
      failures = 0;
      rx_cnt   = 0;
      tx_cnt   = 0;
      ferr_cnt = 0;
      reset    = 1'b0;
      tx_start = 1'b0;
      din      = 8'h00;
      loopback = 1'b1;
      rx_drv   = 1'b1;

      test_reset();
      test_loopback();
      test_tx_wave();
      test_busy();
      test_glitch();
      test_reset_mid();
`ifdef UART_FRAME_ERR_EN
      test_frame_err();
`endif

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d bytes outstanding, required 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
